ysyx_22041071_ifu_axi_rd: RTL

//  AXI4 read-channel master feeding the IF stage: accepts one fetch request (PC), issues a single-beat
//  AR, collects the R beat and presents it to IF as cpu_r_valid/cpu_r_data/cpu_r_addr/cpu_resp.

---
 rtl/ysyx_22041071_ifu_axi_rd.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_22041071_ifu_axi_rd.sv
// IF-stage AXI4 read master: one single-beat fetch in flight, redirect (flush) aware.
// Optional R-wait watchdog enabled by defining YSYX_22041071_IFU_RD_TMO_EN.
module ysyx_22041071_ifu_axi_rd #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned ID_W    = 4,
  parameter int unsigned RD_ID   = 0,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  input  logic              flush,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  output logic [ID_W-1:0]   arid,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic [ID_W-1:0]   rid,
  output logic              cpu_r_valid,
  input  logic              cpu_r_ready,
  output logic [DATA_W-1:0] cpu_r_data,
  output logic [ADDR_W-1:0] cpu_r_addr,
  output logic [1:0]        cpu_resp
);

  typedef enum logic [1:0] {StIdle, StAr, StR, StOut} state_e;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_araddr;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_drop;
  logic                r_cpu_r_valid;
  logic [DATA_W-1:0]   r_cpu_r_data;
  logic [ADDR_W-1:0]   r_cpu_r_addr;
  logic [1:0]          r_cpu_resp;
  logic                w_fetch_ready;
  logic [1:0]          w_beat_resp;

`ifdef YSYX_22041071_IFU_RD_TMO_EN
  logic [7:0]          r_tmo_cnt;
`else
  logic                w_tmo_unused;
  assign w_tmo_unused = ^(TMO_CYC[7:0]);
`endif

  // rready still high outside R means a timed-out beat has not been sunk yet.
  assign w_fetch_ready = reset_n && (r_state == StIdle) && !flush && !r_rready;
  assign w_beat_resp   = ((rid != ID_W'(RD_ID)) || !rlast) ? 2'b10 : rresp;

  assign fetch_ready = w_fetch_ready;
  assign arvalid     = r_arvalid;
  assign araddr      = r_araddr;
  assign arid        = ID_W'(RD_ID);
  assign arlen       = 8'd0;
  assign arsize      = 3'd3;
  assign arburst     = 2'b01;
  assign rready      = r_rready;
  assign cpu_r_valid = r_cpu_r_valid;
  assign cpu_r_data  = r_cpu_r_data;
  assign cpu_r_addr  = r_cpu_r_addr;
  assign cpu_resp    = r_cpu_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= StIdle;
      r_addr        <= '0;
      r_araddr      <= '0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_drop        <= 1'b0;
      r_cpu_r_valid <= 1'b0;
      r_cpu_r_data  <= '0;
      r_cpu_r_addr  <= '0;
      r_cpu_resp    <= 2'b00;
`ifdef YSYX_22041071_IFU_RD_TMO_EN
      r_tmo_cnt     <= 8'd0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (fetch_valid && w_fetch_ready) begin
            r_addr    <= fetch_addr;
            r_araddr  <= fetch_addr & ~ADDR_W'(7);
            r_arvalid <= 1'b1;
            r_state   <= StAr;
          end
`ifdef YSYX_22041071_IFU_RD_TMO_EN
          if (r_rready && rvalid) begin
            r_rready <= 1'b0;
            r_drop   <= 1'b0;
          end
`endif
        end
        StAr: begin
          // AR must complete even when redirected; the beat is dropped later.
          if (flush) r_drop <= 1'b1;
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StR;
`ifdef YSYX_22041071_IFU_RD_TMO_EN
            r_tmo_cnt <= 8'd0;
`endif
          end
        end
        StR: begin
          if (rvalid) begin
            r_rready <= 1'b0;
            if (r_drop || flush) begin
              r_drop  <= 1'b0;
              r_state <= StIdle;
            end else begin
              r_cpu_r_data  <= rdata;
              r_cpu_resp    <= w_beat_resp;
              r_cpu_r_addr  <= r_addr;
              r_cpu_r_valid <= 1'b1;
              r_state       <= StOut;
            end
          end else begin
            if (flush) r_drop <= 1'b1;
`ifdef YSYX_22041071_IFU_RD_TMO_EN
            if (r_tmo_cnt == 8'(TMO_CYC - 1)) begin
              r_cpu_r_data  <= '0;
              r_cpu_resp    <= 2'b11;
              r_cpu_r_addr  <= r_addr;
              r_cpu_r_valid <= 1'b1;
              r_drop        <= 1'b1;
              r_state       <= StOut;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
`endif
          end
        end
        StOut: begin
          if (flush || cpu_r_ready) begin
            r_cpu_r_valid <= 1'b0;
            r_state       <= StIdle;
          end
`ifdef YSYX_22041071_IFU_RD_TMO_EN
          if (r_rready && rvalid) begin
            r_rready <= 1'b0;
            r_drop   <= 1'b0;
          end
`endif
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
